display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan_pkg.sv | 26 ++
 rtl/display_scan_tick.sv | 37 +++
 rtl/display_scan.sv | 143 ++++++++++++++
 tb/tb_display_scan.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_pkg.sv
// ============================================================================
// Module      : display_scan_pkg
// Description : Shared constants, types and a nibble-select helper for the
//               eight-digit multiplexed display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_scan_pkg;

    localparam int NDIG  = 8;
    localparam int IDX_W = 3;
    localparam logic [NDIG-1:0] AN_OFF = 8'hFF;

    typedef logic [3:0]        nibble_t;
    typedef logic [NDIG-1:0]   mask_t;
    typedef logic [4*NDIG-1:0] word_t;
    typedef logic [IDX_W-1:0]  idx_t;

    function automatic nibble_t nibble_at(input word_t w, input idx_t i);
        return w[4*i +: 4];
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_tick.sv
// ============================================================================
// Module      : scan_tick
// Description : Slot prescaler; counts 0..DIV-1 and flags the last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_tick
    import display_scan_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == CNT_W'(DIV - 1));
    assign cnt  = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_scan.sv
// ============================================================================
// Module      : display_scan
// Description : Eight-digit multiplexed display scanner with frame-aligned
//               double buffering. Optional macro LEADING_ZERO_BLANK_EN darkens
//               leading zero digits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan
    import display_scan_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_in,
    input  logic        load,
    output logic [3:0]  num,
    output logic [7:0]  an,
    output logic        dp_n,
    output logic        busy,
    output logic        frame
);

    localparam int CNT_W = $clog2(DIV);

    logic             w_tick;
    logic [CNT_W-1:0] w_cnt;

    idx_t    r_idx;
    word_t   r_shadow_data, r_pend_data;
    mask_t   r_shadow_dp, r_pend_dp;
    mask_t   r_shadow_en, r_pend_en;
    logic    r_busy;
    mask_t   r_an;
    nibble_t r_num;
    logic    r_dp_n;
    logic    r_frame;

    logic    w_frame_end;
    logic    w_digit_on;
    mask_t   w_lzb;
    mask_t   w_an;
    nibble_t w_num;
    logic    w_dp_n;
    logic    w_frame;

    scan_tick #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick),
        .cnt  (w_cnt)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k goes dark when it and every more-significant nibble are zero.
    for (genvar k = 0; k < NDIG; k++) begin : g_lzb
        if (k == 0) begin : g_first
            assign w_lzb[k] = 1'b0;
        end else begin : g_upper
            assign w_lzb[k] = (r_shadow_data[4*NDIG-1:4*k] == '0);
        end
    end
`else
    assign w_lzb = '0;
`endif

    assign w_frame_end = w_tick && (r_idx == idx_t'(NDIG - 1));

    always_comb begin
        w_digit_on = 1'b0;
        w_an       = AN_OFF;
        w_dp_n     = 1'b1;
        w_num      = nibble_at(r_shadow_data, r_idx);
        w_frame    = (w_cnt == '0) && (r_idx == '0);
        if ((w_cnt >= CNT_W'(BLANK)) && r_shadow_en[r_idx] && !w_lzb[r_idx]) begin
            w_digit_on = 1'b1;
        end
        if (w_digit_on) begin
            w_an   = ~(mask_t'(1) << r_idx);
            w_dp_n = ~r_shadow_dp[r_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx         <= '0;
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_shadow_en   <= '0;
            r_pend_data   <= '0;
            r_pend_dp     <= '0;
            r_pend_en     <= '0;
            r_busy        <= 1'b0;
            r_an          <= AN_OFF;
            r_num         <= '0;
            r_dp_n        <= 1'b1;
            r_frame       <= 1'b0;
        end else begin
            r_an    <= w_an;
            r_num   <= w_num;
            r_dp_n  <= w_dp_n;
            r_frame <= w_frame;
            if (w_tick) begin
                r_idx <= r_idx + 1'b1;
            end
            // A load landing on the boundary bypasses the pending buffer.
            if (w_frame_end) begin
                r_busy <= 1'b0;
                if (load) begin
                    r_shadow_data <= data_in;
                    r_shadow_dp   <= dp_in;
                    r_shadow_en   <= en_in;
                end else if (r_busy) begin
                    r_shadow_data <= r_pend_data;
                    r_shadow_dp   <= r_pend_dp;
                    r_shadow_en   <= r_pend_en;
                end
            end else if (load) begin
                r_pend_data <= data_in;
                r_pend_dp   <= dp_in;
                r_pend_en   <= en_in;
                r_busy      <= 1'b1;
            end
        end
    end

    assign num   = r_num;
    assign an    = r_an;
    assign dp_n  = r_dp_n;
    assign busy  = r_busy;
    assign frame = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_display_scan.sv
// ============================================================================
// Module      : tb_display_scan
// Description : Directed, table-driven bench for display_scan (DIV=4, BLANK=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  en_in = '0;
    logic        load = 1'b0;
    logic [3:0]  num;
    logic [7:0]  an;
    logic        dp_n;
    logic        busy;
    logic        frame;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZB = 1'b1;
`else
    localparam logic LZB = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic        ld;
        logic [31:0] d;
        logic [7:0]  dp;
        logic [7:0]  en;
        logic [7:0]  an;
        logic [3:0]  num;
        logic        dpn;
        logic        busy;
        logic        frame;
    } vec_t;

    vec_t tab[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;

    display_scan #(
        .DIV   (4),
        .BLANK (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .dp_in   (dp_in),
        .en_in   (en_in),
        .load    (load),
        .num     (num),
        .an      (an),
        .dp_n    (dp_n),
        .busy    (busy),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(int c, logic [7:0] a, logic [3:0] n, logic dpn,
                                logic b, logic f);
        vec_t v;
        v.cyc = c; v.ld = 1'b0; v.d = '0; v.dp = '0; v.en = '0;
        v.an = a; v.num = n; v.dpn = dpn; v.busy = b; v.frame = f;
        return v;
    endfunction

    function automatic vec_t mkl(vec_t v, logic [31:0] d, logic [7:0] dp, logic [7:0] en);
        vec_t r;
        r = v; r.ld = 1'b1; r.d = d; r.dp = dp; r.en = en;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        cyc++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    endtask

    task automatic check_all(input vec_t v);
        check("an",    32'(an),    32'(v.an));
        check("num",   32'(num),   32'(v.num));
        check("dp_n",  32'(dp_n),  32'(v.dpn));
        check("busy",  32'(busy),  32'(v.busy));
        check("frame", 32'(frame), 32'(v.frame));
    endtask

    initial begin
        // Reset, then blank frame; mid-frame load of 89ABCDEF shown next frame.
        tab.push_back(mk(0,  8'hFF, 4'h0, 1, 0, 0));
        tab.push_back(mk(1,  8'hFF, 4'h0, 1, 0, 1));
        tab.push_back(mk(2,  8'hFF, 4'h0, 1, 0, 0));
        tab.push_back(mkl(mk(5, 8'hFF, 4'h0, 1, 0, 0), 32'h89ABCDEF, 8'h00, 8'hFF));
        tab.push_back(mk(6,  8'hFF, 4'h0, 1, 1, 0));
        tab.push_back(mk(31, 8'hFF, 4'h0, 1, 1, 0));
        tab.push_back(mk(32, 8'hFF, 4'h0, 1, 0, 0));
        tab.push_back(mk(33, 8'hFF, 4'hF, 1, 0, 1));
        tab.push_back(mk(34, 8'hFE, 4'hF, 1, 0, 0));
        tab.push_back(mk(37, 8'hFF, 4'hE, 1, 0, 0));
        tab.push_back(mk(38, 8'hFD, 4'hE, 1, 0, 0));
        tab.push_back(mk(42, 8'hFB, 4'hD, 1, 0, 0));
        tab.push_back(mk(46, 8'hF7, 4'hC, 1, 0, 0));
        tab.push_back(mk(50, 8'hEF, 4'hB, 1, 0, 0));
        tab.push_back(mk(54, 8'hDF, 4'hA, 1, 0, 0));
        tab.push_back(mk(58, 8'hBF, 4'h9, 1, 0, 0));
        tab.push_back(mk(62, 8'h7F, 4'h8, 1, 0, 0));
        tab.push_back(mk(65, 8'hFF, 4'hF, 1, 0, 1));
        // Two loads in one frame: only the second is ever displayed.
        tab.push_back(mkl(mk(70, 8'hFD, 4'hE, 1, 0, 0), 32'h11111111, 8'h00, 8'hFF));
        tab.push_back(mk(71, 8'hFD, 4'hE, 1, 1, 0));
        tab.push_back(mkl(mk(80, 8'hF7, 4'hC, 1, 1, 0), 32'h22222222, 8'h00, 8'hFF));
        tab.push_back(mk(81, 8'hFF, 4'hB, 1, 1, 0));
        tab.push_back(mk(95, 8'h7F, 4'h8, 1, 1, 0));
        tab.push_back(mk(96, 8'h7F, 4'h8, 1, 0, 0));
        tab.push_back(mk(97, 8'hFF, 4'h2, 1, 0, 1));
        tab.push_back(mk(98, 8'hFE, 4'h2, 1, 0, 0));
        tab.push_back(mk(110, 8'hF7, 4'h2, 1, 0, 0));
        tab.push_back(mk(126, 8'h7F, 4'h2, 1, 0, 0));
        // Load on the idx 7 tick goes straight to the display.
        tab.push_back(mkl(mk(127, 8'h7F, 4'h2, 1, 0, 0), 32'h13579BDF, 8'h00, 8'hFF));
        tab.push_back(mk(128, 8'h7F, 4'h2, 1, 0, 0));
        tab.push_back(mk(129, 8'hFF, 4'hF, 1, 0, 1));
        tab.push_back(mk(130, 8'hFE, 4'hF, 1, 0, 0));
        tab.push_back(mk(133, 8'hFF, 4'hD, 1, 0, 0));
        // Enable mask 0F and decimal point on digit 0.
        tab.push_back(mkl(mk(140, 8'hFB, 4'hB, 1, 0, 0), 32'h13579BDF, 8'h01, 8'h0F));
        tab.push_back(mk(141, 8'hFF, 4'h9, 1, 1, 0));
        tab.push_back(mk(160, 8'h7F, 4'h1, 1, 0, 0));
        tab.push_back(mk(161, 8'hFF, 4'hF, 1, 0, 1));
        tab.push_back(mk(162, 8'hFE, 4'hF, 0, 0, 0));
        tab.push_back(mk(164, 8'hFE, 4'hF, 0, 0, 0));
        tab.push_back(mk(165, 8'hFF, 4'hD, 1, 0, 0));
        tab.push_back(mk(166, 8'hFD, 4'hD, 1, 0, 0));
        tab.push_back(mk(178, 8'hFF, 4'h7, 1, 0, 0));
        tab.push_back(mk(186, 8'hFF, 4'h3, 1, 0, 0));
        tab.push_back(mk(190, 8'hFF, 4'h1, 1, 0, 0));
        // Leading-zero data 00000450.
        tab.push_back(mkl(mk(195, 8'hFE, 4'hF, 0, 0, 0), 32'h00000450, 8'h00, 8'hFF));
        tab.push_back(mk(196, 8'hFE, 4'hF, 0, 1, 0));
        tab.push_back(mk(224, 8'hFF, 4'h1, 1, 0, 0));
        tab.push_back(mk(225, 8'hFF, 4'h0, 1, 0, 1));
        tab.push_back(mk(226, 8'hFE, 4'h0, 1, 0, 0));
        tab.push_back(mk(230, 8'hFD, 4'h5, 1, 0, 0));
        tab.push_back(mk(234, 8'hFB, 4'h4, 1, 0, 0));
        tab.push_back(mk(238, LZB ? 8'hFF : 8'hF7, 4'h0, 1, 0, 0));
        tab.push_back(mk(250, LZB ? 8'hFF : 8'hBF, 4'h0, 1, 0, 0));
        tab.push_back(mk(254, LZB ? 8'hFF : 8'h7F, 4'h0, 1, 0, 0));
        // Load that a reset will later discard.
        tab.push_back(mkl(mk(260, 8'hFE, 4'h0, 1, 0, 0), 32'hAAAAAAAA, 8'hFF, 8'hFF));
        tab.push_back(mk(261, 8'hFF, 4'h5, 1, 1, 0));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        for (int i = 0; i < tab.size(); i++) begin
            while (cyc < tab[i].cyc) step();
            check_all(tab[i]);
            if (tab[i].ld) begin
                data_in = tab[i].d;
                dp_in   = tab[i].dp;
                en_in   = tab[i].en;
                load    = 1'b1;
            end
        end

        // Reset mid-slot with a load pending.
        step();
        check_all(mk(262, 8'hFD, 4'h5, 1, 1, 0));
        rst = 1'b1;
        step();
        check_all(mk(263, 8'hFF, 4'h0, 1, 0, 0));
        rst = 1'b0;
        cyc = 0;
        step();
        check_all(mk(1, 8'hFF, 4'h0, 1, 0, 1));
        step();
        check_all(mk(2, 8'hFF, 4'h0, 1, 0, 0));
        while (cyc < 32) step();
        check_all(mk(32, 8'hFF, 4'h0, 1, 0, 0));
        step();
        check_all(mk(33, 8'hFF, 4'h0, 1, 0, 1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
